// File: rtl/decimal_key_scheduler.sv
// Decimal keypad front end: sync + debounce ten key lines, queue presses as pending
// requests, and serve them round-robin as BCD codes over a valid/ready handshake.

module decimal_to_bcd (
  input  logic [9:0] i_dec,
  output logic [3:0] o_bcd
);

  // Input is one-hot (or zero), so OR-ing the set positions yields the code
  always_comb begin
    o_bcd = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (i_dec[i]) o_bcd = o_bcd | 4'(i);
    end
  end

endmodule

module decimal_key_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_in,
  output logic [3:0] bcd_out,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic [9:0] pending,
  output logic       overrun,
  output logic       busy
);

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CYCLES);

  typedef enum logic {S_IDLE, S_VALID} state_t;

  state_t     r_state, w_next;
  logic [9:0] r_sync1, r_sync2, r_deb;
  logic [7:0] r_cnt [10];
  logic [9:0] r_pending;
  logic [3:0] r_bcd, r_gidx, r_rr;
  logic       r_overrun;

  logic [9:0] w_flip, w_press, w_clr, w_grant_oh;
  logic [4:0] w_j;
  logic [3:0] w_gidx, w_enc;
  logic       w_found, w_xfer;

  // Synchronizer, then stage boundary into the per-bit debounce counters
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      w_flip[i] = (r_sync2[i] != r_deb[i]) && ((r_cnt[i] + 8'd1) == DEB_LIM);
    end
    w_press = w_flip & r_sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 10; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 10; i++) begin
        if (r_sync2[i] == r_deb[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
        if (w_flip[i]) r_deb[i] <= r_sync2[i];
      end
    end
  end

  // Round-robin search: first pending digit at or above r_rr, wrapping modulo 10
  always_comb begin
    w_found = 1'b0;
    w_gidx  = 4'd0;
    w_j     = 5'd0;
    for (int k = 0; k < 10; k++) begin
      w_j = {1'b0, r_rr} + 5'(k);
      if (w_j >= 5'd10) w_j = w_j - 5'd10;
      if (!w_found && r_pending[w_j[3:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_j[3:0];
      end
    end
  end

  assign w_grant_oh = w_found ? (10'd1 << w_gidx) : 10'd0;

  decimal_to_bcd u_enc (
    .i_dec (w_grant_oh),
    .o_bcd (w_enc)
  );

  assign w_xfer = (r_state == S_VALID) && bcd_ready;
  assign w_clr  = w_xfer ? (10'd1 << r_gidx) : 10'd0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found)   w_next = S_VALID;
      S_VALID: if (bcd_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A press landing on the clearing edge re-arms the request instead of reporting overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_overrun <= 1'b0;
      r_bcd     <= '0;
      r_gidx    <= '0;
      r_rr      <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= (r_pending & ~w_clr) | w_press;
      r_overrun <= |(w_press & r_pending & ~w_clr);
      if (r_state == S_IDLE && w_found) begin
        r_bcd  <= w_enc;
        r_gidx <= w_gidx;
      end
      if (w_xfer) r_rr <= (r_gidx == 4'd9) ? 4'd0 : r_gidx + 4'd1;
    end
  end

  assign bcd_out   = r_bcd;
  assign bcd_valid = (r_state == S_VALID);
  assign pending   = r_pending;
  assign overrun   = r_overrun;
  assign busy      = (|r_pending) | bcd_valid;

endmodule

// File: tb/tb_decimal_key_scheduler.sv
// Bench for decimal_key_scheduler: vector table, directed corner sequences and a
// random run, all checked every cycle against a behavioural reference model.

module tb_decimal_key_scheduler;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_in;
  logic [3:0] bcd_out;
  logic       bcd_valid;
  logic       bcd_ready;
  logic [9:0] pending;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decimal_key_scheduler #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .pending   (pending),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Reference model: sync as a 2-deep delay, debounce as "last DEB sampled levels all
  // disagree with the debounced level since its last flip", requests as a bit set.
  bit [9:0] ms1, ms2, mdeb;
  bit [9:0] hist [64];
  int       mlast [10];
  int       t = 0;
  bit       mpend [10];
  bit       mvalid, movr;
  int       mout, mgidx, mrr;

  int       out_q [$];
  int       ovr_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] mpend_vec();
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = mpend[i];
    return v;
  endfunction

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mdeb = '0;
    for (int i = 0; i < 64; i++) hist[i] = '0;
    for (int i = 0; i < 10; i++) begin
      mlast[i] = t;
      mpend[i] = 1'b0;
    end
    mvalid = 1'b0; movr = 1'b0; mout = 0; mgidx = 0; mrr = 0;
  endtask

  task automatic model_step(input logic [9:0] k, input logic r);
    bit [9:0] ndeb;
    bit       press [10];
    bit       clr [10];
    bit       xfer, found, all_diff;
    t++;
    hist[t % 64] = ms2;
    xfer = mvalid && r;
    ndeb = mdeb;
    movr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clr[i]   = xfer && (i == mgidx);
      press[i] = 1'b0;
      if (t - mlast[i] >= DEB) begin
        all_diff = 1'b1;
        for (int d = 0; d < DEB; d++) begin
          if (hist[(t - d) % 64][i] == mdeb[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          ndeb[i]  = ~mdeb[i];
          mlast[i] = t;
          press[i] = ndeb[i];
        end
      end
    end
    if (mvalid) begin
      if (r) begin
        mvalid = 1'b0;
        mrr    = (mgidx + 1) % 10;
      end
    end else begin
      found = 1'b0;
      for (int k2 = 0; k2 < 10; k2++) begin
        if (!found && mpend[(mrr + k2) % 10]) begin
          found  = 1'b1;
          mgidx  = (mrr + k2) % 10;
          mout   = mgidx;
          mvalid = 1'b1;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (press[i] && mpend[i] && !clr[i]) movr = 1'b1;
      mpend[i] = (mpend[i] && !clr[i]) || press[i];
    end
    mdeb = ndeb;
    ms2  = ms1;
    ms1  = k;
  endtask

  // One clock: drive at the falling edge, step the model, compare after the next fall
  task automatic tick(input logic [9:0] k, input logic r);
    key_in    = k;
    bcd_ready = r;
    if (bcd_valid === 1'b1 && r) out_q.push_back(int'(bcd_out));
    model_step(k, r);
    @(posedge clk);
    @(negedge clk);
    if (overrun === 1'b1) ovr_cnt++;
    chk("bcd_valid", bcd_valid, mvalid);
    if (mvalid) chk("bcd_out", bcd_out, mout);
    chk("pending", pending, mpend_vec());
    chk("overrun", overrun, movr);
    chk("busy", busy, (mpend_vec() != 0) || mvalid);
  endtask

  task automatic ticks(input int n, input logic [9:0] k, input logic r);
    for (int i = 0; i < n; i++) tick(k, r);
  endtask

  task automatic do_reset(input string nm);
    rst_n     = 1'b0;
    key_in    = '0;
    bcd_ready = 1'b0;
    #1;
    chk({nm, "_rst_valid"},   bcd_valid, 0);
    chk({nm, "_rst_out"},     bcd_out,   0);
    chk({nm, "_rst_pending"}, pending,   0);
    chk({nm, "_rst_overrun"}, overrun,   0);
    chk({nm, "_rst_busy"},    busy,      0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         digit;
    int         hold;
    bit         exp_req;
    logic [3:0] exp_bcd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7, 10, 1'b1, 4'd7};
    vecs[1] = '{4,  3, 1'b0, 4'd0};
    vecs[2] = '{4,  4, 1'b1, 4'd4};
    vecs[3] = '{0,  6, 1'b1, 4'd0};
    vecs[4] = '{9,  5, 1'b1, 4'd9};
    vecs[5] = '{3,  1, 1'b0, 4'd0};
    vecs[6] = '{5,  2, 1'b0, 4'd0};
    vecs[7] = '{1,  8, 1'b1, 4'd1};

    rst_n = 1'b0; key_in = '0; bcd_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset("init");

    // Latency of a single press of digit 7 with the sink stalled
    for (int j = 0; j < 16; j++) begin
      tick(10'h080, 1'b0);
      chk("lat_pending", pending, (j >= 5) ? 10'h080 : 10'h000);
      chk("lat_valid", bcd_valid, (j >= 6) ? 1 : 0);
      if (j >= 6) chk("lat_out", bcd_out, 4'd7);
    end
    tick(10'h000, 1'b1);
    chk("lat_done_valid", bcd_valid, 0);
    chk("lat_done_pending", pending, 0);
    chk("lat_done_busy", busy, 0);
    ticks(8, 10'h000, 1'b0);

    // Vector table: press width vs. accepted request
    foreach (vecs[v]) begin
      ticks(vecs[v].hold, 10'd1 << vecs[v].digit, 1'b0);
      ticks(10, 10'h000, 1'b0);
      chk($sformatf("vec%0d_valid", v), bcd_valid, vecs[v].exp_req);
      chk($sformatf("vec%0d_pending", v), pending,
          vecs[v].exp_req ? (10'd1 << vecs[v].digit) : 10'd0);
      if (vecs[v].exp_req) chk($sformatf("vec%0d_out", v), bcd_out, vecs[v].exp_bcd);
      tick(10'h000, 1'b1);
      ticks(2, 10'h000, 1'b0);
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Simultaneous presses served in round-robin order
    do_reset("rr");
    out_q.delete();
    ticks(6, 10'b10_0010_0100, 1'b1);
    ticks(14, 10'h000, 1'b1);
    chk("rr1_count", out_q.size(), 3);
    if (out_q.size() == 3) begin
      chk("rr1_first", out_q[0], 2);
      chk("rr1_second", out_q[1], 5);
      chk("rr1_third", out_q[2], 9);
    end
    out_q.delete();
    ticks(6, 10'b00_0000_1010, 1'b1);
    ticks(14, 10'h000, 1'b1);
    chk("rr2_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      chk("rr2_first", out_q[0], 1);
      chk("rr2_second", out_q[1], 3);
    end

    // Re-press of a granted, still pending digit
    do_reset("ovrA");
    ticks(6, 10'h040, 1'b0);
    ticks(6, 10'h000, 1'b0);
    ovr_cnt = 0;
    ticks(6, 10'h040, 1'b0);
    ticks(6, 10'h000, 1'b0);
    chk("ovrA_pulses", ovr_cnt, 1);
    chk("ovrA_out", bcd_out, 4'd6);
    out_q.delete();
    ticks(10, 10'h000, 1'b1);
    chk("ovrA_deliveries", out_q.size(), 1);

    // Two presses of 6 queued behind a stalled grant of 1
    do_reset("ovrB");
    ticks(6, 10'h002, 1'b0);
    ticks(6, 10'h000, 1'b0);
    ovr_cnt = 0;
    ticks(6, 10'h040, 1'b0);
    ticks(6, 10'h000, 1'b0);
    ticks(6, 10'h040, 1'b0);
    ticks(6, 10'h000, 1'b0);
    chk("ovrB_pulses", ovr_cnt, 1);
    chk("ovrB_pending", pending, 10'h042);
    out_q.delete();
    ticks(12, 10'h000, 1'b1);
    chk("ovrB_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      chk("ovrB_first", out_q[0], 1);
      chk("ovrB_second", out_q[1], 6);
    end

    // New press of 0 landing on the edge that transfers 0
    do_reset("coll");
    ticks(6, 10'h001, 1'b0);
    ticks(8, 10'h000, 1'b0);
    chk("coll_pre_valid", bcd_valid, 1);
    ticks(5, 10'h001, 1'b0);
    tick(10'h001, 1'b1);
    chk("coll_pending", pending, 10'h001);
    chk("coll_overrun", overrun, 0);
    chk("coll_valid_gap", bcd_valid, 0);
    tick(10'h001, 1'b0);
    chk("coll_valid2", bcd_valid, 1);
    chk("coll_out2", bcd_out, 4'd0);
    ticks(10, 10'h000, 1'b1);
    chk("coll_drained", pending, 0);

    // Asynchronous reset in the middle of a handshake
    do_reset("mid_pre");
    ticks(6, 10'b10_0000_0101, 1'b0);
    ticks(8, 10'h000, 1'b0);
    chk("mid_valid", bcd_valid, 1);
    chk("mid_pending", pending, 10'b10_0000_0101);
    #2;
    do_reset("mid");
    ticks(12, 10'h000, 1'b0);
    chk("mid_after_valid", bcd_valid, 0);
    chk("mid_after_pending", pending, 0);
    ticks(6, 10'h008, 1'b0);
    ticks(4, 10'h000, 1'b0);
    chk("mid_new_valid", bcd_valid, 1);
    chk("mid_new_out", bcd_out, 4'd3);

    // Random key activity and backpressure against the model
    begin
      logic [9:0] kr;
      kr = '0;
      do_reset("rand");
      for (int n = 0; n < 1500; n++) begin
        for (int b = 0; b < 10; b++) begin
          if ($urandom_range(0, 7) == 0) kr[b] = ~kr[b];
        end
        tick(kr, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
